// File: rtl/pc_sched_pkg.sv
// Shared types and constants for the performance-counter dump scheduler.
package pc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BUS  = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    ADVANCE   = 3'd4
  } state_t;

  localparam int unsigned SLOT_BYTES_DEF = 384;

  function automatic int unsigned pend_width(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/pc_slot_ring.sv
// Wrap-around dump slot index and the registered DDR record address for the next dump.
module pc_slot_ring #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned SLOT_BYTES     = 384,
  parameter int unsigned SLOT_W         = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic                      i_advance,
  input  logic [AXI_ADDR_WIDTH-1:0] i_base,
  input  logic [SLOT_W-1:0]         i_num_slots,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr,
  output logic [SLOT_W-1:0]         o_slot_idx
);

  logic [SLOT_W-1:0]         r_slot_idx;
  logic [SLOT_W-1:0]         w_last_slot;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_offset;

  // A ring size of 0 behaves as a single slot.
  assign w_last_slot = (i_num_slots == '0) ? '0 : i_num_slots - SLOT_W'(1);
  assign w_offset    = AXI_ADDR_WIDTH'(r_slot_idx) * AXI_ADDR_WIDTH'(SLOT_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_idx <= '0;
      r_addr     <= '0;
    end else begin
      if (i_load) begin
        r_addr <= i_base + w_offset;
      end
      // >= so a ring shrunk below the current index wraps on the next advance.
      if (i_advance) begin
        r_slot_idx <= (r_slot_idx >= w_last_slot) ? '0 : r_slot_idx + SLOT_W'(1);
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_slot_idx = r_slot_idx;

endmodule

// File: rtl/pc_dump_scheduler.sv
// Queues counter-dump triggers, waits for a free AXI write channel, starts the dump
// engine with a ring-slot address and tracks completions, drops and timeouts.
module pc_dump_scheduler
  import pc_sched_pkg::*;
#(
  parameter  int unsigned AXI_ADDR_WIDTH = 64,
  parameter  int unsigned SLOT_BYTES     = SLOT_BYTES_DEF,
  parameter  int unsigned SLOT_W         = 8,
  parameter  int unsigned MAX_PENDING    = 7,
  parameter  int unsigned TIMEOUT_CYCLES = 4096,
  parameter  int unsigned CNT_W          = 32,
  localparam int unsigned PEND_W         = pend_width(MAX_PENDING)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dump_req,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [SLOT_W-1:0]         cfg_num_slots,
  input  logic                      axi_wr_busy,
  output logic                      pc_start,
  output logic [AXI_ADDR_WIDTH-1:0] pc_axi_addr,
  input  logic                      pc_done,
  output logic                      pc_freeze,
  output logic                      pc_wr_grant,
  output logic                      sched_busy,
  output logic [PEND_W-1:0]         pending_cnt,
  output logic [CNT_W-1:0]          dump_count,
  output logic [CNT_W-1:0]          drop_count,
  output logic                      timeout_err,
  input  logic                      err_clear,
  output state_t                    dbg_state,
  output logic [SLOT_W-1:0]         dbg_slot_idx
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: dump_req, pc_start and pc_done are single-cycle pulses with no
  // back-pressure; a trigger is either queued or counted as dropped that cycle.
  state_t              r_state, w_next_state;
  logic [PEND_W-1:0]   r_pending;
  logic [TMO_W-1:0]    r_tmo, w_tmo_next;
  logic [CNT_W-1:0]    r_dump_count, r_drop_count;
  logic                r_timeout_err;
  logic                w_deq, w_full, w_drop, w_tmo_hit, w_tmo_set, w_advance;

  assign w_deq      = (r_state == IDLE) && (r_pending != '0);
  assign w_full     = (r_pending == PEND_W'(MAX_PENDING));
  assign w_drop     = dump_req && w_full && !w_deq;
  assign w_tmo_next = r_tmo + TMO_W'(1);
  assign w_tmo_hit  = (r_state == WAIT_DONE) && (w_tmo_next == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_tmo_set  = w_tmo_hit && !pc_done;
  assign w_advance  = (r_state == ADVANCE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (r_pending != '0) w_next_state = WAIT_BUS;
      WAIT_BUS:  if (!axi_wr_busy) w_next_state = START;
      START:     w_next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (pc_done)        w_next_state = ADVANCE;
        else if (w_tmo_hit) w_next_state = IDLE;
      end
      ADVANCE:   w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    pc_start    = 1'b0;
    pc_freeze   = 1'b0;
    pc_wr_grant = 1'b0;
    case (r_state)
      WAIT_BUS:  pc_freeze = 1'b1;
      START: begin
        pc_start    = 1'b1;
        pc_freeze   = 1'b1;
        pc_wr_grant = 1'b1;
      end
      WAIT_DONE: begin
        pc_freeze   = 1'b1;
        pc_wr_grant = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= '0;
      r_tmo         <= '0;
      r_dump_count  <= '0;
      r_drop_count  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (dump_req && !w_deq && !w_full) r_pending <= r_pending + PEND_W'(1);
      else if (w_deq && !dump_req)       r_pending <= r_pending - PEND_W'(1);

      if (r_state == START)          r_tmo <= '0;
      else if (r_state == WAIT_DONE) r_tmo <= w_tmo_next;

      if (w_advance) r_dump_count <= r_dump_count + CNT_W'(1);

      if (err_clear)                      r_drop_count <= '0;
      else if (w_drop && r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);

      if (err_clear)      r_timeout_err <= 1'b0;
      else if (w_tmo_set) r_timeout_err <= 1'b1;
    end
  end

  pc_slot_ring #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .SLOT_BYTES     (SLOT_BYTES),
    .SLOT_W         (SLOT_W)
  ) u_slot_ring (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_deq),
    .i_advance   (w_advance),
    .i_base      (cfg_base_addr),
    .i_num_slots (cfg_num_slots),
    .o_addr      (pc_axi_addr),
    .o_slot_idx  (dbg_slot_idx)
  );

  assign sched_busy  = (r_state != IDLE) || (r_pending != '0);
  assign pending_cnt = r_pending;
  assign dump_count  = r_dump_count;
  assign drop_count  = r_drop_count;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_dump_scheduler.sv
// Directed bench for pc_dump_scheduler: cycle table for single dump and bus contention,
// hand-written sequences for ring wrap, timeout, overflow and reset mid-dump.
module tb_pc_dump_scheduler;
  import pc_sched_pkg::*;

  localparam int AW  = 64;
  localparam int SW  = 8;
  localparam int MP  = 7;
  localparam int TMO = 16;
  localparam int CW  = 32;
  localparam int PW  = 3;

  logic          clk = 1'b0;
  logic          reset, dump_req, axi_wr_busy, pc_done, err_clear;
  logic [AW-1:0] cfg_base_addr;
  logic [SW-1:0] cfg_num_slots;
  logic          pc_start, pc_freeze, pc_wr_grant, sched_busy, timeout_err;
  logic [AW-1:0] pc_axi_addr;
  logic [PW-1:0] pending_cnt;
  logic [CW-1:0] dump_count, drop_count;
  state_t        dbg_state;
  logic [SW-1:0] dbg_slot_idx;

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_q[$];

  pc_dump_scheduler #(
    .AXI_ADDR_WIDTH (AW), .SLOT_BYTES (384), .SLOT_W (SW),
    .MAX_PENDING (MP), .TIMEOUT_CYCLES (TMO), .CNT_W (CW)
  ) dut (
    .clk (clk), .reset (reset), .dump_req (dump_req),
    .cfg_base_addr (cfg_base_addr), .cfg_num_slots (cfg_num_slots),
    .axi_wr_busy (axi_wr_busy), .pc_start (pc_start), .pc_axi_addr (pc_axi_addr),
    .pc_done (pc_done), .pc_freeze (pc_freeze), .pc_wr_grant (pc_wr_grant),
    .sched_busy (sched_busy), .pending_cnt (pending_cnt), .dump_count (dump_count),
    .drop_count (drop_count), .timeout_err (timeout_err), .err_clear (err_clear),
    .dbg_state (dbg_state), .dbg_slot_idx (dbg_slot_idx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_ctl"}, {pc_start, pc_freeze, pc_wr_grant, sched_busy, pending_cnt,
                          timeout_err, dbg_state, dbg_slot_idx}, 64'd0);
    check({tag, "_cnt"}, {dump_count, drop_count}, 64'd0);
    check({tag, "_addr"}, pc_axi_addr, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; dump_req = 1'b0; pc_done = 1'b0; err_clear = 1'b0; axi_wr_busy = 1'b0;
    step();
    step();
    chk_reset(tag);
    reset = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (pc_start !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({name, "_start_seen"}, pc_start, 1'b1);
  endtask

  // One complete dump with pc_done lat cycles after pc_start (lat >= 1).
  task automatic do_dump(input string name, input int lat);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_start(name);
    repeat (lat) step();
    pc_done = 1'b1;
    step();
    pc_done = 1'b0;
    step();
  endtask

  // ---------------- scoreboard: address of every pc_start pulse ----------------
  always @(negedge clk) begin
    if (pc_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL start_addr: unexpected pc_start at addr 0x%0h", pc_axi_addr);
      end else begin
        check("start_addr", pc_axi_addr, exp_q.pop_front());
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          req, busy, done, clr;
    state_t        st;
    logic          start, freeze, grant, sbusy;
    logic [PW-1:0] pend;
    logic          terr;
    logic [7:0]    dcnt;
    logic [SW-1:0] slot;
    string         tag;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic req, busy, done, clr, input state_t st,
                       input logic start, freeze, grant, sbusy, input int pend,
                       input logic terr, input int dcnt, input int slot, input string tag);
    vec_t v;
    v.req = req; v.busy = busy; v.done = done; v.clr = clr; v.st = st;
    v.start = start; v.freeze = freeze; v.grant = grant; v.sbusy = sbusy;
    v.pend = PW'(pend); v.terr = terr; v.dcnt = 8'(dcnt); v.slot = SW'(slot); v.tag = tag;
    vecs.push_back(v);
  endtask

  logic [AW-1:0] wrap_addrs [5];

  initial begin
    reset = 1'b1; dump_req = 1'b0; axi_wr_busy = 1'b0; pc_done = 1'b0; err_clear = 1'b0;
    cfg_base_addr = 64'h1000;
    cfg_num_slots = 8'd4;
    wrap_addrs = '{64'h1000, 64'h1180, 64'h1300, 64'h1480, 64'h1000};

    // Single dump, pc_done 10 cycles after pc_start.
    add_v(1,0,0,0, IDLE,      0,0,0,1, 1, 0, 0, 0, "t1_req");
    add_v(0,0,0,0, WAIT_BUS,  0,1,0,1, 0, 0, 0, 0, "t1_deq");
    add_v(0,0,0,0, START,     1,1,1,1, 0, 0, 0, 0, "t1_start");
    for (int i = 0; i < 10; i++)
      add_v(0,0,0,0, WAIT_DONE, 0,1,1,1, 0, 0, 0, 0, "t1_wait");
    add_v(0,0,1,0, ADVANCE,   0,0,0,1, 0, 0, 0, 0, "t1_adv");
    add_v(0,0,0,0, IDLE,      0,0,0,0, 0, 0, 1, 1, "t1_idle");
    // Bus contention: busy for 20 cycles after the trigger; early pc_done in START ignored.
    add_v(1,1,0,0, IDLE,      0,0,0,1, 1, 0, 1, 1, "t3_req");
    for (int i = 0; i < 20; i++)
      add_v(0,1,0,0, WAIT_BUS,  0,1,0,1, 0, 0, 1, 1, "t3_busy");
    add_v(0,0,0,0, START,     1,1,1,1, 0, 0, 1, 1, "t3_start");
    add_v(0,0,1,0, WAIT_DONE, 0,1,1,1, 0, 0, 1, 1, "t3_done_in_start");
    add_v(0,0,1,0, ADVANCE,   0,0,0,1, 0, 0, 1, 1, "t3_adv");
    add_v(0,0,0,0, IDLE,      0,0,0,0, 0, 0, 2, 2, "t3_idle");

    do_reset("reset0");

    exp_q.push_back(64'h1000);
    exp_q.push_back(64'h1180);
    foreach (vecs[i]) begin
      dump_req = vecs[i].req; axi_wr_busy = vecs[i].busy;
      pc_done = vecs[i].done; err_clear = vecs[i].clr;
      step();
      check($sformatf("vec%0d_%s", i, vecs[i].tag),
            {dbg_state, pc_start, pc_freeze, pc_wr_grant, sched_busy, pending_cnt,
             timeout_err, dump_count[7:0], dbg_slot_idx},
            {vecs[i].st, vecs[i].start, vecs[i].freeze, vecs[i].grant, vecs[i].sbusy,
             vecs[i].pend, vecs[i].terr, vecs[i].dcnt, vecs[i].slot});
    end
    dump_req = 1'b0; axi_wr_busy = 1'b0; pc_done = 1'b0; err_clear = 1'b0;

    // Ring wrap over 4 slots.
    do_reset("reset1");
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(wrap_addrs[i]);
      do_dump($sformatf("wrap%0d", i), 3);
    end
    check("wrap_dump_count", dump_count, 64'd5);
    check("wrap_slot", dbg_slot_idx, 64'd1);

    // Timeout with a second trigger queued behind it; retry reuses the slot address.
    exp_q.push_back(64'h1180);
    exp_q.push_back(64'h1180);
    dump_req = 1'b1;
    step();
    step();
    dump_req = 1'b0;
    wait_start("tmo_first");
    repeat (TMO - 1) step();
    check("tmo_before_limit", timeout_err, 1'b0);
    step();
    check("tmo_at_limit", {timeout_err, dbg_state, pending_cnt}, {1'b1, IDLE, 3'd1});
    check("tmo_no_advance", {dump_count[7:0], dbg_slot_idx}, {8'd5, 8'd1});
    wait_start("tmo_retry");
    repeat (2) step();
    pc_done = 1'b1;
    step();
    pc_done = 1'b0;
    step();
    check("tmo_retry_done", {dump_count[7:0], dbg_slot_idx, 7'd0, timeout_err},
          {8'd6, 8'd2, 7'd0, 1'b1});
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("tmo_cleared", timeout_err, 1'b0);

    // pc_done on the timeout-limit cycle counts as success.
    exp_q.push_back(64'h1300);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_start("limit_done");
    repeat (TMO - 1) step();
    pc_done = 1'b1;
    step();
    pc_done = 1'b0;
    check("limit_done_adv", {dbg_state, timeout_err}, {ADVANCE, 1'b0});
    step();
    check("limit_done_count", {dump_count[7:0], dbg_slot_idx}, {8'd7, 8'd3});

    // Overflow while a dump is in flight, err_clear vs drop, req on a dequeue cycle.
    exp_q.push_back(64'h1480);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_start("ovf");
    for (int i = 0; i < 9; i++) begin
      dump_req = 1'b1;
      step();
    end
    check("ovf_pending_cap", pending_cnt, 64'd7);
    check("ovf_drop_count", drop_count, 64'd2);
    err_clear = 1'b1;
    step();
    dump_req = 1'b0;
    err_clear = 1'b0;
    check("ovf_clear_beats_drop", {drop_count, 29'd0, pending_cnt}, {32'd0, 29'd0, 3'd7});
    pc_done = 1'b1;
    step();
    pc_done = 1'b0;
    step();
    check("ovf_idle_full", {dbg_state, pending_cnt, dump_count[7:0], dbg_slot_idx},
          {IDLE, 3'd7, 8'd8, 8'd0});
    exp_q.push_back(64'h1000);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    check("same_cycle_req_deq", {dbg_state, pending_cnt, drop_count}, {WAIT_BUS, 3'd7, 32'd0});
    wait_start("ovf_next");

    // Reset in WAIT_DONE with three triggers pending; late pc_done ignored.
    do_reset("reset2");
    exp_q.push_back(64'h1000);
    repeat (4) begin
      dump_req = 1'b1;
      step();
    end
    dump_req = 1'b0;
    check("mid_dump_state", {dbg_state, pending_cnt}, {WAIT_DONE, 3'd3});
    reset = 1'b1;
    step();
    chk_reset("mid_reset");
    reset = 1'b0;
    pc_done = 1'b1;
    step();
    pc_done = 1'b0;
    check("late_done_ignored", {dbg_state, sched_busy, dump_count}, {IDLE, 1'b0, 32'd0});

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_dump_scheduler.md
Name: pc_dump_scheduler

Overview:
Sequences performance-counter dumps to DDR. Queues dump triggers from the controller (e.g. end of layer/tile), waits until the shared AXI write channel is idle, pulses the counter-dump engine's start, and supplies a per-dump DDR address from a wrap-around slot ring. While a dump is in flight it freezes the counters, and it reports timeouts, dropped triggers and completed dumps.

Parameters:
AXI_ADDR_WIDTH, 64, DDR byte-address width
SLOT_BYTES, 384, bytes per dump record (6 beats x 64 B)
SLOT_W, 8, width of slot index / cfg_num_slots
MAX_PENDING, 7, max queued triggers (pending counter width = $clog2(MAX_PENDING+1))
TIMEOUT_CYCLES, 4096, max cycles from pc_start to pc_done
CNT_W, 32, width of dump/drop statistic counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dump_req  in  1  1-cycle trigger requesting one dump
cfg_base_addr  in  AXI_ADDR_WIDTH  DDR base of slot ring; sampled in IDLE->WAIT_BUS
cfg_num_slots  in  SLOT_W  ring size; 0 treated as 1
axi_wr_busy  in  1  other store engine owns the AXI write channel
pc_start  out  1  1-cycle start pulse to dump engine
pc_axi_addr  out  AXI_ADDR_WIDTH  record address for the current dump
pc_done  in  1  1-cycle completion from dump engine
pc_freeze  out  1  hold counters stable while high
pc_wr_grant  out  1  write channel reserved for the dump (other engines must not start)
sched_busy  out  1  state != IDLE or pending != 0
pending_cnt  out  $clog2(MAX_PENDING+1)  queued triggers
dump_count  out  CNT_W  completed dumps (wraps)
drop_count  out  CNT_W  dropped triggers (saturates)
timeout_err  out  1  sticky; set on timeout
err_clear  in  1  clears timeout_err and drop_count

Behaviour:
- Reset values: every output is 0, the state is IDLE and slot_idx is 0. A reset mid-dump abandons the dump with no completion and no error.
- Pending counter:
  - +1 on dump_req; -1 on dequeue (IDLE->WAIT_BUS).
  - dump_req and dequeue in the same cycle: no net change.
  - dump_req while pending==MAX_PENDING and no dequeue that cycle: the trigger is dropped and drop_count increments (saturating).
- States:
  - IDLE: if pending!=0, go to WAIT_BUS; dequeue; latch base. pc_axi_addr <= base + slot_idx*SLOT_BYTES (registered, full address width, truncating).
  - WAIT_BUS: pc_freeze=1. If !axi_wr_busy, go to START; otherwise stay (no timeout while waiting).
  - START: pc_start=1 for exactly one cycle; pc_wr_grant=1; pc_freeze=1; the timeout counter is cleared; go to WAIT_DONE.
  - WAIT_DONE:
    - pc_wr_grant=1 and pc_freeze=1; the timeout counter increments.
    - pc_done: go to ADVANCE.
    - Otherwise, counter reaching TIMEOUT_CYCLES-1: set timeout_err and go to IDLE. The slot does not advance and dump_count is not incremented.
  - ADVANCE: dump_count+1. slot_idx <= (slot_idx == eff_slots-1) ? 0 : slot_idx+1, where eff_slots = max(cfg_num_slots,1). Go to IDLE.
- Timing:
  - pc_freeze is high in WAIT_BUS, START and WAIT_DONE; it deasserts in the cycle ADVANCE is entered.
  - pc_wr_grant is high only in START and WAIT_DONE.
- pc_done outside WAIT_DONE is ignored.
- pc_done in the same cycle as the timeout limit counts as success.
- Minimum dump-to-dump spacing is 4 cycles plus the dump engine latency.
- cfg_num_slots is reduced below slot_idx+1: the next ADVANCE wraps to 0 (use >= compare).
- Errors:
  - err_clear has priority over a same-cycle set of timeout_err (clear wins).
  - err_clear has priority over a same-cycle drop increment (drop_count=0).
- pc_axi_addr holds its value from WAIT_BUS until the next dequeue.

Decomposition:
- Package pc_sched_pkg:
  - state enum {IDLE, WAIT_BUS, START, WAIT_DONE, ADVANCE}
  - SLOT_BYTES default constant
  - pending-width function
- Sub-module pc_slot_ring: slot_idx register, wrap compare and address multiply-add (registered output).
- The FSM, pending counter and statistics remain in the top module.

Test Plan:
1. Single dump:
   - Stimulus: base=0x1000, cfg_num_slots=4, one dump_req, axi_wr_busy=0, pc_done 10 cycles after pc_start.
   - Response: pc_start pulses once with pc_axi_addr=0x1000; dump_count=1; slot_idx=1.
2. Ring wrap:
   - Stimulus: 5 sequential dumps, cfg_num_slots=4.
   - Response: addresses 0x1000, 0x1180, 0x1300, 0x1480, then 0x1000.
3. Bus contention:
   - Stimulus: axi_wr_busy=1 for 20 cycles after dump_req.
   - Response: pc_freeze=1 and pc_start=0 throughout; pc_start fires in the cycle after busy drops; no timeout_err.
4. Overflow and simultaneous events:
   - Stimulus: 9 back-to-back dump_req while a dump is in flight; also dump_req in the same cycle as a dequeue.
   - Response: pending_cnt caps at 7; drop_count=2; the same-cycle case leaves pending_cnt unchanged.
5. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, pc_done never arrives.
   - Response: timeout_err=1 exactly 16 cycles after pc_start; slot_idx and dump_count unchanged; the next queued dump reuses the same address; err_clear resets timeout_err to 0.
6. Reset mid-dump:
   - Stimulus: assert reset during WAIT_DONE with pending=3.
   - Response: next cycle all outputs are 0, the state is IDLE, and a late pc_done is ignored.
